// File: rtl/rcc_div_sel_ctrl.sv
// Divider ratio-switch controller: applies a new select code on a divided-clock
// boundary, waits SETTLE_CNT further boundaries, then reports done (or err on timeout).
`timescale 1ns/1ps
module rcc_div_sel_ctrl #(
    parameter int unsigned SETTLE_CNT = 2,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic       i_clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [2:0] req_sel,
    output logic       req_ready,
    input  logic       div_en,
    output logic [2:0] div_sel,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        SETTLE    = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CNT - 1);
    localparam logic [7:0] TO_LAST     = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [2:0] div_sel_q, div_sel_d;
    logic [2:0] pend_q, pend_d;
    logic [3:0] set_cnt_q, set_cnt_d;
    logic [7:0] to_cnt_q, to_cnt_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic [7:0] to_inc_s;

    // Codes without the top bit all mean divide-by-1 and collapse to 000.
    function automatic logic [2:0] norm_sel(input logic [2:0] sel);
        logic [2:0] res;
        if (sel[2]) begin
            res = sel;
        end else begin
            res = 3'b000;
        end
        return res;
    endfunction

    // Next-state, counters and status pulses.
    always_comb begin
        state_d   = state_q;
        div_sel_d = div_sel_q;
        pend_d    = pend_q;
        set_cnt_d = set_cnt_q;
        to_cnt_d  = to_cnt_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        if (to_cnt_q == 8'hFF) begin
            to_inc_s = to_cnt_q;
        end else begin
            to_inc_s = to_cnt_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    pend_d = norm_sel(req_sel);
                    if (norm_sel(req_sel) == div_sel_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = WAIT_EDGE;
                        to_cnt_d  = 8'd0;
                        set_cnt_d = 4'd0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_EDGE: begin
                // A boundary beats a simultaneous timeout.
                if (div_en) begin
                    div_sel_d = pend_q;
                    state_d   = SETTLE;
                    set_cnt_d = 4'd0;
                    to_cnt_d  = 8'd0;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    to_cnt_d = to_inc_s;
                end
            end
            SETTLE: begin
                if (div_en) begin
                    to_cnt_d = 8'd0;
                    if (set_cnt_q == SETTLE_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        set_cnt_d = set_cnt_q + 4'd1;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    to_cnt_d = to_inc_s;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            div_sel_q <= 3'b000;
            pend_q    <= 3'b000;
            set_cnt_q <= 4'd0;
            to_cnt_q  <= 8'd0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_sel_q <= div_sel_d;
            pend_q    <= pend_d;
            set_cnt_q <= set_cnt_d;
            to_cnt_q  <= to_cnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign div_sel   = div_sel_q;
    assign busy      = (state_q != IDLE);
    assign req_ready = (state_q == IDLE);
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_rcc_div_sel_ctrl.sv
// Bench for rcc_div_sel_ctrl: directed scenarios plus random requests, predicted
// by a transaction-level model that scans the planned div_en sequence.
`timescale 1ns/1ps
module tb_rcc_div_sel_ctrl;

    localparam int SC   = 2;
    localparam int TO   = 64;
    localparam int MAXK = 512;

    logic       i_clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic [2:0] req_sel;
    logic       div_en;
    logic       req_ready;
    logic [2:0] div_sel;
    logic       busy;
    logic       done;
    logic       err;

    int         n_cmp = 0;
    int         n_bad = 0;
    bit         en_pat [MAXK];
    logic [2:0] cur_sel;

    rcc_div_sel_ctrl #(.SETTLE_CNT(SC), .TIMEOUT(TO)) dut (
        .i_clk    (i_clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_sel  (req_sel),
        .req_ready(req_ready),
        .div_en   (div_en),
        .div_sel  (div_sel),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #900000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_s(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic clear_pat();
        for (int k = 0; k < MAXK; k++) en_pat[k] = 1'b0;
    endtask

    // density: div_en high with probability 1/density; zeros from cut onward
    task automatic rand_pat(input int density, input int cut);
        for (int k = 0; k < MAXK; k++)
            en_pat[k] = (k < cut) && ($urandom_range(density - 1, 0) == 0);
    endtask

    // Walk the planned boundary sequence: the first boundary applies the
    // code, SC more finish it, TO consecutive idle cycles abort it.
    // kind: 0 done, 1 err, 2 unresolved. kend: offset of the final edge.
    function automatic void predict(input logic [2:0] tgt, output int kind,
                                    output int kend, output int ksw);
        int gap;
        int bnd;
        kind = 2; kend = MAXK - 1; ksw = -1; gap = 0; bnd = 0;
        if (tgt == cur_sel) begin
            kind = 0; kend = 0;
            return;
        end
        for (int k = 1; k < MAXK; k++) begin
            if (en_pat[k]) begin
                gap = 0;
                if (ksw < 0) begin
                    ksw = k;
                end else begin
                    bnd++;
                    if (bnd == SC) begin kind = 0; kend = k; return; end
                end
            end else begin
                gap++;
                if (gap == TO) begin kind = 1; kend = k; return; end
            end
        end
    endfunction

    task automatic run_req(input string name, input logic [2:0] code);
        int kind, kend, ksw;
        logic [2:0] tgt, old;
        old = cur_sel;
        tgt = (code >= 3'd4) ? code : 3'd0;
        predict(tgt, kind, kend, ksw);
        for (int k = 0; k <= kend; k++) begin
            if (k == 0) begin
                req_valid = 1'b1;
                req_sel   = code;
            end else begin
                req_valid = 1'($urandom_range(1, 0));
                req_sel   = 3'($urandom_range(7, 0));
            end
            div_en = en_pat[k];
            @(posedge i_clk);
            @(negedge i_clk);
            chk_b({name, ".busy"},  busy,      k < kend);
            chk_b({name, ".ready"}, req_ready, !(k < kend));
            chk_b({name, ".done"},  done,      (k == kend) && (kind == 0));
            chk_b({name, ".err"},   err,       (k == kend) && (kind == 1));
            chk_s({name, ".div_sel"}, div_sel, (ksw >= 0 && k >= ksw) ? tgt : old);
        end
        req_valid = 1'b0;
        div_en    = 1'b0;
        if (ksw >= 0) cur_sel = tgt;
    endtask

    task automatic chk_reset_outs(input string name);
        chk_s({name, ".div_sel"}, div_sel, 3'b000);
        chk_b({name, ".busy"},  busy,      1'b0);
        chk_b({name, ".ready"}, req_ready, 1'b1);
        chk_b({name, ".done"},  done,      1'b0);
        chk_b({name, ".err"},   err,       1'b0);
    endtask

    initial begin
        logic [2:0] c;
        rst_n = 1'b0; req_valid = 1'b0; req_sel = 3'b000; div_en = 1'b0;
        cur_sel = 3'b000;
        #1;
        chk_reset_outs("reset");
        @(negedge i_clk);
        @(negedge i_clk);
        rst_n = 1'b1;
        @(negedge i_clk);
        chk_reset_outs("post_reset");

        // normal switch: boundaries 3 cycles after acceptance then every 2
        clear_pat(); en_pat[3] = 1'b1; en_pat[5] = 1'b1; en_pat[7] = 1'b1;
        run_req("normal", 3'b110);

        clear_pat(); en_pat[2] = 1'b1; en_pat[4] = 1'b1; en_pat[6] = 1'b1;
        run_req("to101", 3'b101);
        clear_pat(); en_pat[0] = 1'b1;
        run_req("same", 3'b101);

        clear_pat(); en_pat[1] = 1'b1; en_pat[2] = 1'b1; en_pat[3] = 1'b1;
        run_req("to100", 3'b100);
        clear_pat(); en_pat[2] = 1'b1; en_pat[3] = 1'b1; en_pat[9] = 1'b1;
        run_req("norm", 3'b010);

        clear_pat();
        run_req("to_wait", 3'b111);

        // boundary on the timeout-threshold cycle wins
        clear_pat(); en_pat[64] = 1'b1; en_pat[66] = 1'b1; en_pat[68] = 1'b1;
        run_req("tie", 3'b111);

        clear_pat(); en_pat[1] = 1'b1;
        run_req("to_settle", 3'b100);

        // reset in SETTLE
        c = (cur_sel == 3'b110) ? 3'b101 : 3'b110;
        req_valid = 1'b1; req_sel = c; div_en = 1'b0;
        @(posedge i_clk); @(negedge i_clk);
        req_valid = 1'b0;
        chk_b("rst_mid.busy_wait", busy, 1'b1);
        div_en = 1'b1;
        @(posedge i_clk); @(negedge i_clk);
        div_en = 1'b0;
        chk_s("rst_mid.div_sel", div_sel, c);
        chk_b("rst_mid.busy_settle", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("rst_mid.async");
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            chk_b("rst_mid.no_done", done, 1'b0);
            chk_b("rst_mid.no_err",  err,  1'b0);
        end
        rst_n = 1'b1;
        cur_sel = 3'b000;
        clear_pat(); en_pat[2] = 1'b1; en_pat[3] = 1'b1; en_pat[5] = 1'b1;
        run_req("after_rst", 3'b111);

        for (int r = 0; r < 40; r++) begin
            case ($urandom_range(3, 0))
                0:       rand_pat(2, MAXK);
                1:       rand_pat(8, MAXK);
                2:       rand_pat(40, MAXK);
                default: rand_pat(4, int'($urandom_range(6, 0)));
            endcase
            run_req("rand", 3'($urandom_range(7, 0)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rcc_div_sel_ctrl.md
RCC_DIV_SEL_CTRL -- requirements
Module: rcc_div_sel_ctrl

Interface
REQ-001 Parameter SETTLE_CNT, default 2: number of divided-clock boundaries to wait after a ratio switch before done; legal values 1..15.
REQ-002 Parameter TIMEOUT, default 64: maximum i_clk cycles to wait for a boundary in any waiting state; legal values 32..255.
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  ratio-change request strobe.
REQ-006 req_sel  input  3  requested divider select code; 100=/2, 101=/4, 110=/8, 111=/16, any other code=/1.
REQ-007 req_ready  output  1  request can be accepted; equals !busy.
REQ-008 div_en  input  1  divider boundary marker, one i_clk cycle high per divided-clock period.
REQ-009 div_sel  output  3  registered select code driven to the divider.
REQ-010 busy  output  1  ratio change in progress.
REQ-011 done  output  1  one-cycle pulse: request completed successfully.
REQ-012 err  output  1  one-cycle pulse: request aborted on timeout.

Function
REQ-013 States SHALL be IDLE, WAIT_EDGE and SETTLE; busy=1 exactly when the state is not IDLE.
REQ-014 A request SHALL be accepted on an edge where req_valid=1 and req_ready=1; req_valid while busy SHALL be ignored, with no queuing.
REQ-015 On acceptance, req_sel SHALL be normalized: codes 000..011 become 000; codes 100..111 pass unchanged. The result SHALL be latched as the pending select.
REQ-016 If the normalized code equals the current div_sel, the block SHALL stay in IDLE and pulse done in the next cycle; busy SHALL never assert.
REQ-017 Otherwise the block SHALL enter WAIT_EDGE in the next cycle and clear the timeout counter.
REQ-018 In WAIT_EDGE, on the first edge with div_en=1:
- div_sel SHALL load the pending select, visible the next cycle;
- the state SHALL go to SETTLE;
- the settle counter and timeout counter SHALL clear.
REQ-019 The div_en cycle that triggers the switch SHALL NOT count toward SETTLE_CNT.
REQ-020 In SETTLE, each edge with div_en=1 SHALL increment the settle counter and clear the timeout counter.
REQ-021 On the SETTLE edge with div_en=1 and settle counter=SETTLE_CNT-1, the block SHALL return to IDLE and pulse done in the following cycle.
REQ-022 The timeout counter SHALL increment on each WAIT_EDGE or SETTLE cycle with div_en=0; it SHALL saturate and never wrap.
REQ-023 When the timeout counter reaches TIMEOUT-1 with div_en=0 in WAIT_EDGE, the block SHALL:
- return to IDLE;
- leave div_sel unchanged;
- pulse err in the next cycle.
REQ-024 On the same timeout condition in SETTLE, the block SHALL return to IDLE, keep the new div_sel and pulse err in the next cycle.
REQ-025 If div_en=1 and the timeout threshold occur on the same edge, div_en SHALL win and no err SHALL be raised.
REQ-026 done and err SHALL never be asserted together; each SHALL be exactly one cycle wide.
REQ-027 A new request SHALL be acceptable in the same cycle that done or err is high.
REQ-028 div_sel SHALL change only on an edge where the block is in WAIT_EDGE with div_en=1; it SHALL never change in any other cycle.

Reset
REQ-029 While rst_n=0, all outputs SHALL take their reset values immediately, independent of i_clk: div_sel=000, busy=0, req_ready=1, done=0, err=0.
REQ-030 While rst_n=0, state SHALL be IDLE and all counters and the pending select SHALL be cleared.
REQ-031 Reset asserted mid-operation SHALL abandon the request with no done or err pulse; after deassertion the block SHALL accept a request on the first edge.

Verification
REQ-032 The bench SHALL cover the following scenarios:
- Normal switch: from reset, req_sel=110; div_en pulses 3 cycles after acceptance, then every 2 cycles -> div_sel=110 the cycle after the first div_en; done pulses once after the 2nd subsequent div_en; busy is high throughout.
- Same select: div_sel=101, request req_sel=101 -> done the next cycle; busy stays 0; div_sel unchanged.
- Code normalization: div_sel=100, request req_sel=010 -> switch proceeds; div_sel=000 after the boundary.
- Timeout in WAIT_EDGE: request 111 with div_en held 0 -> err pulses after 64 cycles; div_sel unchanged; busy low; req_ready=1.
- Ignored request and timeout tie: req_valid while busy -> dropped, with a single done for the first request. div_en=1 on the timeout-threshold cycle -> no err.
- Reset mid-SETTLE: rst_n low -> div_sel=000 and busy=0 immediately; no done or err pulse.
